// File: rtl/uart_tx_arb_pkg.sv
// Shared types for the uart_tx arbiter: FSM encoding, counter width,
// and a constant log2 helper for index widths.
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_HOLD,
      S_WAIT
   } state_t;

   localparam int CNT_W = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after the
// pointer, wrapping, returned as one-hot grant plus binary index.
module uart_tx_arb_rr_pick
   import uart_tx_arb_pkg::*;
#(
   parameter int NCH = 4,
   parameter int IW  = clog2(NCH)
) (
   input  logic [NCH-1:0] i_req,
   input  logic [IW-1:0]  i_ptr,
   output logic [NCH-1:0] o_gnt,
   output logic [IW-1:0]  o_idx,
   output logic           o_any
);

   logic w_found;
   int   w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_j     = 0;
      for (int k = 0; k < NCH; k++) begin
         w_j = (int'(i_ptr) + k) % NCH;
         if (!w_found && i_req[w_j]) begin
            w_found    = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = IW'(w_j);
         end
      end
   end

   assign o_any = w_found;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin, per-packet arbiter sharing one uart_tx among NCH sources.
// Owner keeps the transmitter until its last byte or MAX_BURST bytes.
module uart_tx_arb
   import uart_tx_arb_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int MAX_BURST = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NCH-1:0]   req_vld,
   input  logic [8*NCH-1:0] req_data,
   input  logic [NCH-1:0]   req_last,
   output logic [NCH-1:0]   req_ack,
   output logic [7:0]       dout,
   output logic             dout_vld,
   input  logic             rdy,
   output logic [NCH-1:0]   grant,
   output logic             busy
);

   localparam int IW = clog2(NCH);

   state_t           r_state, w_state;
   logic [IW-1:0]    r_owner, w_owner;
   logic [IW-1:0]    r_ptr, w_ptr;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_last, w_last;
   logic [NCH-1:0]   r_ack, w_ack;
   logic [NCH-1:0]   r_grant, w_grant;
   logic [7:0]       r_dout, w_dout;
   logic             r_vld, w_vld;
   logic             r_busy, w_busy;

   logic [NCH-1:0]   w_pgnt;
   logic [IW-1:0]    w_pidx;
   logic             w_pany;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [IW-1:0]    w_owner_nxt;
   logic [7:0]       w_owner_byte;

   uart_tx_arb_rr_pick #(
      .NCH (NCH),
      .IW  (IW)
   ) u_pick (
      .i_req (req_vld),
      .i_ptr (r_ptr),
      .o_gnt (w_pgnt),
      .o_idx (w_pidx),
      .o_any (w_pany)
   );

   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_owner_byte = req_data[{r_owner, 3'b000} +: 8];
   assign w_owner_nxt  = (r_owner == IW'(NCH - 1)) ?
                         '0 : r_owner + 1'b1;

   always_comb begin
      w_state = r_state;
      w_owner = r_owner;
      w_ptr   = r_ptr;
      w_cnt   = r_cnt;
      w_last  = r_last;
      w_ack   = '0;
      w_grant = r_grant;
      w_dout  = r_dout;
      w_vld   = 1'b0;
      w_busy  = r_busy;
      unique case (r_state)
         S_IDLE: begin
            if (w_pany) begin
               w_owner = w_pidx;
               w_grant = w_pgnt;
               w_busy  = 1'b1;
               w_cnt   = '0;
               w_state = S_SEND;
            end
         end
         S_SEND: begin
            if (rdy && req_vld[r_owner]) begin
               w_dout         = w_owner_byte;
               w_vld          = 1'b1;
               w_ack[r_owner] = 1'b1;
               w_cnt          = w_cnt_inc;
               w_last         = req_last[r_owner] |
                                (w_cnt_inc == CNT_W'(MAX_BURST));
               w_state        = S_HOLD;
            end
         end
         // uart_tx only drops rdy a cycle after it registers din_vld
         S_HOLD: w_state = S_WAIT;
         S_WAIT: begin
            if (rdy) begin
               if (r_last) begin
                  w_ptr   = w_owner_nxt;
                  w_grant = '0;
                  w_busy  = 1'b0;
                  w_state = S_IDLE;
               end else begin
                  w_state = S_SEND;
               end
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
         r_ack   <= '0;
         r_grant <= '0;
         r_dout  <= 8'h00;
         r_vld   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_owner <= w_owner;
         r_ptr   <= w_ptr;
         r_cnt   <= w_cnt;
         r_last  <= w_last;
         r_ack   <= w_ack;
         r_grant <= w_grant;
         r_dout  <= w_dout;
         r_vld   <= w_vld;
         r_busy  <= w_busy;
      end
   end

   assign req_ack  = r_ack;
   assign dout     = r_dout;
   assign dout_vld = r_vld;
   assign grant    = r_grant;
   assign busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: queued sources, a uart_tx rdy model
// and a scoreboard of expected (channel, byte) pairs in emission order.
module tb_uart_tx_arb;

   localparam int NCH   = 4;
   localparam int MB    = 4;
   localparam int FRAME = 20;

   typedef struct {
      int         ch;
      logic [7:0] b;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NCH-1:0]   req_vld;
   logic [8*NCH-1:0] req_data;
   logic [NCH-1:0]   req_last;
   logic [NCH-1:0]   req_ack;
   logic [7:0]       dout;
   logic             dout_vld;
   logic             rdy;
   logic [NCH-1:0]   grant;
   logic             busy;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   logic [8:0] mem[NCH][32];
   int         hd[NCH];
   int         tl[NCH];
   int         acks[NCH];
   int         ucnt;
   logic       stall;

   always #5 clk = ~clk;

   uart_tx_arb #(
      .NCH       (NCH),
      .MAX_BURST (MB)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_vld  (req_vld),
      .req_data (req_data),
      .req_last (req_last),
      .req_ack  (req_ack),
      .dout     (dout),
      .dout_vld (dout_vld),
      .rdy      (rdy),
      .grant    (grant),
      .busy     (busy)
   );

   for (genvar g = 0; g < NCH; g++) begin : g_src
      assign req_vld[g]        = (hd[g] != tl[g]);
      assign req_data[8*g +: 8] = mem[g][hd[g] % 32][7:0];
      assign req_last[g]       = mem[g][hd[g] % 32][8];
   end

   // uart_tx model: registers din_vld, then busy for FRAME cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ucnt <= 0;
      else if (dout_vld) ucnt <= FRAME;
      else if (ucnt > 0) ucnt <= ucnt - 1;
   end
   assign rdy = (ucnt == 0) && !stall;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int ch, input logic [7:0] b,
                       input logic last);
      mem[ch][tl[ch] % 32] = {last, b};
      tl[ch] = tl[ch] + 1;
   endtask

   task automatic expect_b(input int ch, input logic [7:0] b);
      exp_t e;
      e.ch = ch;
      e.b  = b;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && busy == 1'b0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'((exp_q.size() == 0) && (busy == 1'b0)), 1);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NCH; i++)
         if (rst_n && req_ack[i]) begin
            hd[i]   <= hd[i] + 1;
            acks[i] <= acks[i] + 1;
         end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && dout_vld) begin
         chk("byte_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("dout", 32'(dout), 32'(e.b));
            chk("grant_at_vld", 32'(grant), 32'(1 << e.ch));
            chk("ack_at_vld", 32'(req_ack), 32'(1 << e.ch));
         end
      end
   end

   initial begin
      int bad;
      int n;
      int a0;
      int a1;
      rst_n = 1'b0;
      stall = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(req_ack), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_vld", 32'(dout_vld), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single source, three bytes
      push(0, 8'h41, 1'b0);
      push(0, 8'h42, 1'b0);
      push(0, 8'h43, 1'b1);
      expect_b(0, 8'h41);
      expect_b(0, 8'h42);
      expect_b(0, 8'h43);
      wait_idle("single_done");
      chk("single_acks", 32'(acks[0]), 3);
      chk("single_busy", 32'(busy), 0);

      // fairness: pointer now at channel 1
      for (int c = 0; c < NCH; c++)
         for (int p = 0; p < 2; p++)
            for (int b = 0; b < 2; b++)
               push(c, 8'(c * 16 + p * 2 + b), b == 1);
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < NCH; k++)
            for (int b = 0; b < 2; b++)
               expect_b((1 + k) % NCH, 8'(((1 + k) % NCH) * 16 + p * 2 + b));
      wait_idle("fair_done");
      chk("fair_acks3", 32'(acks[3]), 4);

      // burst cap: pointer at channel 1
      for (int i = 0; i < 8; i++) push(1, 8'(8'hA0 + i), 1'b0);
      push(2, 8'hB0, 1'b0);
      push(2, 8'hB1, 1'b1);
      for (int i = 0; i < 4; i++) expect_b(1, 8'(8'hA0 + i));
      expect_b(2, 8'hB0);
      expect_b(2, 8'hB1);
      for (int i = 4; i < 8; i++) expect_b(1, 8'(8'hA0 + i));
      wait_idle("burst_done");

      // rdy stall: pointer at channel 2, only ch3 requests
      stall = 1'b1;
      push(3, 8'hC3, 1'b1);
      expect_b(3, 8'hC3);
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (dout_vld || req_ack != '0) bad++;
      end
      chk("stall_quiet", 32'(bad), 0);
      chk("stall_grant", 32'(grant), 32'h8);
      chk("stall_busy", 32'(busy), 1);
      stall = 1'b0;
      @(negedge clk);
      chk("stall_resume", 32'(dout_vld), 1);
      wait_idle("stall_done");

      // owner gap: pointer at channel 0
      a1 = acks[1];
      a0 = acks[0];
      push(0, 8'hD0, 1'b0);
      push(1, 8'hE1, 1'b1);
      expect_b(0, 8'hD0);
      n = 0;
      while (acks[0] == a0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("gap_first_ack", 32'(acks[0]), 32'(a0 + 1));
      repeat (30) @(negedge clk);
      chk("gap_grant", 32'(grant), 32'h1);
      chk("gap_ch1_held", 32'(acks[1]), 32'(a1));
      push(0, 8'hD1, 1'b0);
      push(0, 8'hD2, 1'b1);
      expect_b(0, 8'hD1);
      expect_b(0, 8'hD2);
      expect_b(1, 8'hE1);
      wait_idle("gap_done");

      // reset mid-packet: ch2 owns, transmitter in WAIT
      push(2, 8'hF0, 1'b0);
      push(2, 8'hF1, 1'b1);
      expect_b(2, 8'hF0);
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk("pre_rst_grant", 32'(grant), 32'h4);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(req_ack), 0);
      chk("mid_rst_vld", 32'(dout_vld), 0);
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      for (int c = 0; c < NCH; c++) tl[c] = hd[c];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push(2, 8'h12, 1'b1);
      push(0, 8'h10, 1'b1);
      expect_b(0, 8'h10);
      expect_b(2, 8'h12);
      wait_idle("post_rst_done");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
